// File: rtl/trap_ctrl.sv
// Trap sequencer sitting between writeback and the CSR file.
// At each instruction boundary it picks one event: an interrupt, an exception,
// an mret or an sret. It then pulses the matching CSR strobe for one cycle.
// Finally it presents the new fetch PC and holds it until fetch accepts it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | watch WB for an interrupt/exception/mret/sret boundary
// TRAP     | trap_enter strobe, vector target computed from tvec
// RET      | mret_exec/sret_exec strobe, target taken from mepc/sepc
// REDIRECT | redirect_valid held with a stable PC until redirect_ready

module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exc,
  input  logic [4:0]  wb_cause,
  input  logic [31:0] wb_tval,
  input  logic        wb_mret,
  input  logic        wb_sret,

  input  logic        timer_interrupt,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic        mip_stip,
  input  logic        mie_stie,
  input  logic        sstatus_sie,
  input  logic        mideleg_sti,
  input  logic [1:0]  priv_mode,
  input  logic        trap_to_s,

  input  logic [31:0] mtvec,
  input  logic [31:0] stvec,
  input  logic [31:0] mepc,
  input  logic [31:0] sepc,

  output logic        wb_kill,
  output logic        flush,
  output logic        busy,
  output logic        trap_enter,
  output logic        mret_exec,
  output logic        sret_exec,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_STI = 32'h8000_0005;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP     = 2'd1,
    ST_RET      = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  state_t      state_q,       state_d;
  logic [31:0] trap_cause_q,  trap_cause_d;
  logic [31:0] trap_pc_q,     trap_pc_d;
  logic [31:0] trap_val_q,    trap_val_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        ret_is_s_q,    ret_is_s_d;

  logic        m_enabled;
  logic        mti_elig;
  logic        sti_elig;
  logic        irq_any;
  logic [31:0] tvec_sel;
  logic [31:0] tvec_base;
  logic        use_vector;
  logic [31:0] trap_target;

  // Interrupt eligibility; M-level enables apply below M or with mstatus.MIE set.
  always_comb begin
    m_enabled = (priv_mode != PRIV_M) | mstatus_mie;
    mti_elig  = timer_interrupt & mie_mtie & m_enabled;
    if (mideleg_sti) begin
      // Delegated STI is never taken while in M.
      sti_elig = mip_stip & mie_stie &
                 ((priv_mode == PRIV_U) | ((priv_mode == PRIV_S) & sstatus_sie));
    end else begin
      sti_elig = mip_stip & mie_stie & m_enabled;
    end
    irq_any = mti_elig | sti_elig;
  end

  // Trap target: trap_to_s is sampled in the TRAP cycle, before priv_mode moves.
  always_comb begin
    tvec_sel    = trap_to_s ? stvec : mtvec;
    tvec_base   = {tvec_sel[31:2], 2'b00};
    use_vector  = VECTORED_EN && (tvec_sel[1:0] == 2'b01) && trap_cause_q[31];
    trap_target = use_vector ? (tvec_base + {25'b0, trap_cause_q[4:0], 2'b00})
                             : tvec_base;
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    trap_cause_d   = trap_cause_q;
    trap_pc_d      = trap_pc_q;
    trap_val_d     = trap_val_q;
    redirect_pc_d  = redirect_pc_q;
    ret_is_s_d     = ret_is_s_q;
    wb_kill        = 1'b0;
    flush          = 1'b0;
    trap_enter     = 1'b0;
    mret_exec      = 1'b0;
    sret_exec      = 1'b0;
    redirect_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wb_valid) begin
          if (irq_any) begin
            wb_kill      = 1'b1;
            flush        = 1'b1;
            trap_cause_d = mti_elig ? CAUSE_MTI : CAUSE_STI;
            trap_pc_d    = wb_pc;
            trap_val_d   = 32'h0;
            state_d      = ST_TRAP;
          end else if (wb_exc) begin
            wb_kill      = 1'b1;
            flush        = 1'b1;
            trap_cause_d = {27'b0, wb_cause};
            trap_pc_d    = wb_pc;
            trap_val_d   = wb_tval;
            state_d      = ST_TRAP;
          end else if (wb_mret) begin
            // mret/sret retire normally; only the younger instructions go.
            flush      = 1'b1;
            ret_is_s_d = 1'b0;
            state_d    = ST_RET;
          end else if (wb_sret) begin
            flush      = 1'b1;
            ret_is_s_d = 1'b1;
            state_d    = ST_RET;
          end
        end
      end

      ST_TRAP: begin
        trap_enter    = 1'b1;
        redirect_pc_d = trap_target;
        state_d       = ST_REDIRECT;
      end

      ST_RET: begin
        mret_exec     = ~ret_is_s_q;
        sret_exec     = ret_is_s_q;
        redirect_pc_d = ret_is_s_q ? sepc : mepc;
        state_d       = ST_REDIRECT;
      end

      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and trap-record registers; reset clears everything visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      trap_cause_q  <= 32'h0;
      trap_pc_q     <= 32'h0;
      trap_val_q    <= 32'h0;
      redirect_pc_q <= 32'h0;
      ret_is_s_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      trap_cause_q  <= trap_cause_d;
      trap_pc_q     <= trap_pc_d;
      trap_val_q    <= trap_val_d;
      redirect_pc_q <= redirect_pc_d;
      ret_is_s_q    <= ret_is_s_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign trap_cause  = trap_cause_q;
  assign trap_pc     = trap_pc_q;
  assign trap_val    = trap_val_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl. Each driven event pushes its expected
// strobe/cause/pc/tval/target record; the record is popped when the DUT strobes.

module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_exc, wb_mret, wb_sret;
  logic [31:0] wb_pc, wb_tval;
  logic [4:0]  wb_cause;
  logic        timer_interrupt, mie_mtie, mstatus_mie, mip_stip, mie_stie;
  logic        sstatus_sie, mideleg_sti, trap_to_s;
  logic [1:0]  priv_mode;
  logic [31:0] mtvec, stvec, mepc, sepc;
  logic        wb_kill, flush, busy, trap_enter, mret_exec, sret_exec;
  logic [31:0] trap_cause, trap_pc, trap_val, redirect_pc;
  logic        redirect_valid, redirect_ready;

  trap_ctrl #(.VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc), .wb_cause(wb_cause),
    .wb_tval(wb_tval), .wb_mret(wb_mret), .wb_sret(wb_sret),
    .timer_interrupt(timer_interrupt), .mie_mtie(mie_mtie), .mstatus_mie(mstatus_mie),
    .mip_stip(mip_stip), .mie_stie(mie_stie), .sstatus_sie(sstatus_sie),
    .mideleg_sti(mideleg_sti), .priv_mode(priv_mode), .trap_to_s(trap_to_s),
    .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
    .wb_kill(wb_kill), .flush(flush), .busy(busy), .trap_enter(trap_enter),
    .mret_exec(mret_exec), .sret_exec(sret_exec), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 trap, 1 mret, 2 sret
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_wb();
    wb_valid = 1'b0; wb_exc = 1'b0; wb_mret = 1'b0; wb_sret = 1'b0;
  endtask

  task automatic push(input int kind, input logic [31:0] cause, input logic [31:0] pc,
                      input logic [31:0] tval, input logic [31:0] target);
    exp_t e;
    e.kind = kind; e.cause = cause; e.pc = pc; e.tval = tval; e.target = target;
    sb.push_back(e);
  endtask

  // Called just after inputs are driven at a falling edge (cycle N).
  task automatic run_event(input string tag, input bit exp_kill, input int stall);
    exp_t e;
    #1;
    chk({tag, ".wb_kill"}, {31'b0, wb_kill}, {31'b0, exp_kill});
    chk({tag, ".flush"},   {31'b0, flush},   32'd1);
    chk({tag, ".busy_n"},  {31'b0, busy},    32'd0);
    @(negedge clk);
    clr_wb();
    e = sb.pop_front();
    chk({tag, ".trap_enter"}, {31'b0, trap_enter}, {31'b0, (e.kind == 0)});
    chk({tag, ".mret_exec"},  {31'b0, mret_exec},  {31'b0, (e.kind == 1)});
    chk({tag, ".sret_exec"},  {31'b0, sret_exec},  {31'b0, (e.kind == 2)});
    chk({tag, ".busy_n1"},    {31'b0, busy},       32'd1);
    if (e.kind == 0) begin
      chk({tag, ".trap_cause"}, trap_cause, e.cause);
      chk({tag, ".trap_pc"},    trap_pc,    e.pc);
      chk({tag, ".trap_val"},   trap_val,   e.tval);
    end
    @(negedge clk);
    for (int i = 0; i <= stall; i++) begin
      redirect_ready = (i == stall);
      chk({tag, ".redirect_valid"}, {31'b0, redirect_valid}, 32'd1);
      chk({tag, ".redirect_pc"},    redirect_pc,             e.target);
      chk({tag, ".strobes_off"},    {29'b0, trap_enter, mret_exec, sret_exec}, 32'd0);
      if (i < stall) @(negedge clk);
    end
    @(negedge clk);
    chk({tag, ".busy_done"},     {31'b0, busy},           32'd0);
    chk({tag, ".redirect_done"}, {31'b0, redirect_valid}, 32'd0);
  endtask

  // WB holds a plain instruction that must not cause any event.
  task automatic no_event(input string tag);
    #1;
    chk({tag, ".wb_kill"}, {31'b0, wb_kill}, 32'd0);
    chk({tag, ".flush"},   {31'b0, flush},   32'd0);
    @(negedge clk);
    clr_wb();
    chk({tag, ".busy"},    {31'b0, busy},    32'd0);
    chk({tag, ".strobes"}, {29'b0, trap_enter, mret_exec, sret_exec}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    clr_wb();
    wb_pc = 0; wb_cause = 0; wb_tval = 0;
    timer_interrupt = 0; mie_mtie = 0; mstatus_mie = 0; mip_stip = 0; mie_stie = 0;
    sstatus_sie = 0; mideleg_sti = 0; trap_to_s = 0; priv_mode = 2'b11;
    mtvec = 32'h8000_0001; stvec = 32'hC000_0000; mepc = 32'h4000; sepc = 32'h5000;
    redirect_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.busy",  {31'b0, busy}, 32'd0);
    chk("rst.strb",  {27'b0, trap_enter, mret_exec, sret_exec, redirect_valid, flush}, 32'd0);
    chk("rst.cause", trap_cause, 32'd0);
    chk("rst.rpc",   redirect_pc, 32'd0);
    rst = 1'b0;

    // Exception to M; exceptions never vector.
    @(negedge clk);
    wb_valid = 1; wb_exc = 1; wb_cause = 5'd2; wb_pc = 32'h100; wb_tval = 32'hDEAD;
    push(0, 32'd2, 32'h100, 32'hDEAD, 32'h8000_0000);
    run_event("exc_m", 1'b1, 0);

    // Vectored MTI from U-mode.
    @(negedge clk);
    priv_mode = 2'b00; timer_interrupt = 1; mie_mtie = 1;
    wb_valid = 1; wb_pc = 32'h2000;
    push(0, 32'h8000_0007, 32'h2000, 32'h0, 32'h8000_001C);
    run_event("mti_vec", 1'b1, 0);

    // Interrupt beats a simultaneous exception.
    @(negedge clk);
    wb_valid = 1; wb_exc = 1; wb_cause = 5'd5; wb_tval = 32'h1234; wb_pc = 32'h3000;
    push(0, 32'h8000_0007, 32'h3000, 32'h0, 32'h8000_001C);
    run_event("irq_vs_exc", 1'b1, 0);

    // Pending MTI with wb_valid=0 takes nothing.
    @(negedge clk);
    #1;
    chk("novalid.flush", {31'b0, flush}, 32'd0);
    @(negedge clk);
    chk("novalid.busy",  {31'b0, busy},  32'd0);

    // M-mode with MIE clear masks MTI; with MIE set and direct mtvec it traps.
    @(negedge clk);
    priv_mode = 2'b11; mstatus_mie = 0; wb_valid = 1; wb_pc = 32'h3100;
    no_event("mti_masked");
    @(negedge clk);
    mstatus_mie = 1; mtvec = 32'h8000_0000; wb_valid = 1; wb_pc = 32'h3200;
    push(0, 32'h8000_0007, 32'h3200, 32'h0, 32'h8000_0000);
    run_event("mti_direct", 1'b1, 0);
    timer_interrupt = 0; mie_mtie = 0; mstatus_mie = 0; mtvec = 32'h8000_0001;

    // Delegated STI from S-mode into stvec.
    @(negedge clk);
    priv_mode = 2'b01; sstatus_sie = 1; mideleg_sti = 1; trap_to_s = 1;
    mip_stip = 1; mie_stie = 1; wb_valid = 1; wb_pc = 32'h6000;
    push(0, 32'h8000_0005, 32'h6000, 32'h0, 32'hC000_0000);
    run_event("sti_deleg", 1'b1, 0);
    @(negedge clk);
    sstatus_sie = 0; wb_valid = 1; wb_pc = 32'h6004;
    no_event("sti_sie0");
    @(negedge clk);
    priv_mode = 2'b11; mstatus_mie = 1; wb_valid = 1; wb_pc = 32'h6008;
    no_event("sti_in_m");

    // Non-delegated STI from U-mode goes to M, vectored.
    @(negedge clk);
    priv_mode = 2'b00; mideleg_sti = 0; trap_to_s = 0; mstatus_mie = 0;
    wb_valid = 1; wb_pc = 32'h7000;
    push(0, 32'h8000_0005, 32'h7000, 32'h0, 32'h8000_0014);
    run_event("sti_m", 1'b1, 0);
    mip_stip = 0; mie_stie = 0;

    // mret with a stalled redirect, then sret.
    @(negedge clk);
    priv_mode = 2'b11; wb_valid = 1; wb_mret = 1; wb_pc = 32'h8000;
    push(1, 32'h0, 32'h0, 32'h0, 32'h4000);
    run_event("mret", 1'b0, 3);
    @(negedge clk);
    wb_valid = 1; wb_sret = 1; wb_pc = 32'h8004;
    push(2, 32'h0, 32'h0, 32'h0, 32'h5000);
    run_event("sret", 1'b0, 0);

    // Reset in TRAP aborts the sequence.
    @(negedge clk);
    wb_valid = 1; wb_exc = 1; wb_cause = 5'd4; wb_pc = 32'h9000; wb_tval = 32'h55;
    @(negedge clk);
    clr_wb();
    chk("rstmid.pre", {31'b0, trap_enter}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid.strb",  {28'b0, trap_enter, busy, redirect_valid, flush}, 32'd0);
    chk("rstmid.cause", trap_cause, 32'd0);
    chk("rstmid.pc",    trap_pc,    32'd0);
    chk("rstmid.val",   trap_val,   32'd0);
    chk("rstmid.rpc",   redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid.quiet", {28'b0, trap_enter, mret_exec, sret_exec, redirect_valid}, 32'd0);
    end

    chk("sb.empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer between the writeback stage and `csr_regfile`. It decides at each instruction boundary whether to take an interrupt, an exception, or an `mret`/`sret`, and drives the CSR file's `trap_enter`/`mret_exec`/`sret_exec` strobes. It also computes the redirect target from `mtvec`/`stvec`/`mepc`/`sepc` and holds the pipeline until the fetch stage accepts the redirect.

## Interface
- `VECTORED_EN`, default 1: honour tvec MODE=01 (vectored interrupts); 0 forces direct mode.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wb_valid` in 1: WB holds a real instruction this cycle.
- `wb_pc` in 32: PC of the WB instruction.
- `wb_exc` in 1: WB instruction raised a synchronous exception.
- `wb_cause` in 5: exception code.
- `wb_tval` in 32: exception value.
- `wb_mret`, `wb_sret` in 1 each: WB instruction is `mret` / `sret`.
- `timer_interrupt` in 1: MTIP.
- `mie_mtie`, `mstatus_mie`, `mip_stip`, `mie_stie`, `sstatus_sie` in 1 each: from `csr_regfile`.
- `mideleg_sti` in 1: `mideleg[5]`.
- `priv_mode` in 2: current privilege.
- `trap_to_s` in 1: delegation decision from `csr_regfile`.
- `mtvec`, `stvec`, `mepc`, `sepc` in 32 each.
- `wb_kill` out 1: suppress retirement of the WB instruction (combinational).
- `flush` out 1: kill all younger instructions (combinational).
- `busy` out 1: pipeline must hold.
- `trap_enter`, `mret_exec`, `sret_exec` out 1 each: one-cycle CSR strobes.
- `trap_cause` out 32, `trap_pc` out 32, `trap_val` out 32: registered, to `csr_regfile`.
- `redirect_valid` out 1, `redirect_pc` out 32: new fetch PC.
- `redirect_ready` in 1: fetch accepts the redirect.

## Operation
States are IDLE, TRAP, RET and REDIRECT.

Interrupt eligibility (evaluated only in IDLE):
- MTI is eligible when `timer_interrupt & mie_mtie & (priv_mode!=M | mstatus_mie)`.
- STI with `mideleg_sti=1` is eligible when `mip_stip & mie_stie & (priv_mode==U | (priv_mode==S & sstatus_sie))`. It is never taken in M.
- STI with `mideleg_sti=0` uses the MTI enable rule with `mip_stip & mie_stie`.
- When both are eligible, MTI wins.

Event priority in IDLE with `wb_valid=1`, highest first:
1. Interrupt: cause `0x8000_0007` (MTI) or `0x8000_0005` (STI), tval 0.
2. `wb_exc`: cause `{27'b0,wb_cause}`, tval `wb_tval`.
3. `wb_mret`.
4. `wb_sret`.

With `wb_valid=0` no event is taken, even if an interrupt is pending.

Combinational outputs in IDLE:
- `wb_kill` = `wb_valid & (interrupt | wb_exc)`. The killed instruction is not retired; `trap_pc` = `wb_pc`.
- `flush` = `wb_valid & (any event)`.
- `mret`/`sret` retire normally: `wb_kill=0`, `flush=1`.

Transitions:
- IDLE -> TRAP on an interrupt or exception. `trap_cause`, `trap_pc`, `trap_val` are registered on entry.
- IDLE -> RET on `mret`/`sret`; the kind is latched.
- TRAP: `trap_enter=1` for exactly one cycle. `trap_to_s` is sampled this cycle, before `priv_mode` updates. Target computation:
  - base = (S ? `stvec` : `mtvec`) & ~3.
  - If `VECTORED_EN` & tvec[1:0]==01 & interrupt: target = base + (cause[4:0]<<2), 32-bit wrap.
  - Otherwise target = base.
  - Next state REDIRECT.
- RET: `mret_exec` or `sret_exec` = 1 for one cycle; target = `mepc` or `sepc` sampled this cycle. Next state REDIRECT.
- REDIRECT: `redirect_valid=1` and `redirect_pc` stable until `redirect_ready`. The cycle `redirect_ready=1` is sampled is the last REDIRECT cycle; next state IDLE.
- `busy`=1 in TRAP, RET and REDIRECT. While busy, all WB inputs and interrupts are ignored.

## Timing
- Reset (asynchronous): state IDLE; every output 0, including `trap_cause`, `trap_pc`, `trap_val`, `redirect_pc`.
- A reset asserted mid-sequence aborts it; no strobe is emitted after reset deasserts.
- Event taken in cycle N:
  - `flush`/`wb_kill` in cycle N.
  - CSR strobe in N+1.
  - `redirect_valid` from N+2.
  - IDLE again in the cycle after `redirect_ready`.
- Minimum event-to-event spacing is 3 cycles (with `redirect_ready` tied 1).
- Strobes are mutually exclusive and never asserted in two consecutive cycles.
- An interrupt arriving while busy stays pending in the CSRs and is evaluated at the first IDLE boundary.

## Test plan
- **Exception to M:** M-mode, `wb_exc=1`, cause 2, pc `0x100`, `mtvec=0x8000_0001`.
  - Cycle N: `wb_kill=1`.
  - N+1: `trap_enter=1`, `trap_cause=2`.
  - N+2: `redirect_pc=0x8000_0000` (exceptions are not vectored).
- **Vectored MTI:** U-mode, MTIP+MTIE, `mtvec=0x8000_0001`, pc `0x2000`.
  - `trap_cause=0x8000_0007`, `trap_pc=0x2000`, `redirect_pc=0x8000_001C`.
- **Interrupt beats exception:** MTI eligible plus `wb_exc=1` in the same cycle.
  - Cause `0x8000_0007`, `trap_val=0`.
- **Delegated STI:** S-mode, `sstatus_sie=1`, `mideleg_sti=1`, `trap_to_s=1`, `stvec=0xC000_0000`.
  - `redirect_pc=0xC000_0000`.
  - Repeating with `sstatus_sie=0` in S-mode: no trap.
- **mret with stalled redirect:** `mepc=0x4000`, `wb_mret=1`.
  - `wb_kill=0`; `mret_exec` one cycle.
  - `redirect_valid` held for 3 cycles with `redirect_ready=0`, then accepted; `busy` drops the next cycle.
- **Reset mid-sequence:** assert `rst` in TRAP.
  - All outputs 0 immediately; after release no strobe appears until a new event.
